midterm_demux: RTL and testbench

//  Inverse of the 3:1 channel mux: the 3:1 mux selects one of the C/K/F nibbles onto a shared bus.

---
 rtl/midterm_demux_if.sv | 31 +++
 rtl/midterm_demux.sv | 90 +++++++++
 tb/tb_midterm_demux.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/midterm_demux_if.sv
// Bundle between the shared nibble bus, the demux and its three channel consumers.
// The slave side is the demux; the master side drives the words and the channel readies.
interface midterm_demux_if #(
  parameter int W  = 4,
  parameter int CW = 8
);
  logic [W-1:0]  in_data;
  logic [1:0]    in_sel;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  c_data;
  logic          c_valid;
  logic          c_ready;
  logic [W-1:0]  k_data;
  logic          k_valid;
  logic          k_ready;
  logic [W-1:0]  f_data;
  logic          f_valid;
  logic          f_ready;
  logic [CW-1:0] drop_count;

  modport slave (
    input  in_data, in_sel, in_valid, c_ready, k_ready, f_ready,
    output in_ready, c_data, c_valid, k_data, k_valid, f_data, f_valid, drop_count
  );

  modport master (
    output in_data, in_sel, in_valid, c_ready, k_ready, f_ready,
    input  in_ready, c_data, c_valid, k_data, k_valid, f_data, f_valid, drop_count
  );
endinterface

// File: rtl/midterm_demux.sv
// Routes one nibble stream to the C, K or F channel by its select code; code 3 words are
// swallowed and counted. Each channel is a one-entry register with a valid/ready handshake.
module midterm_demux #(
  parameter int W  = 4,
  parameter int CW = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  midterm_demux_if.slave   bus
);

  typedef enum logic {EMPTY, FULL} chan_state_t;

  localparam int NCH = 3;

  chan_state_t       state  [NCH];
  logic [W-1:0]      data_q [NCH];
  logic [NCH-1:0]    chan_ready;
  logic [NCH-1:0]    space;
  logic [NCH-1:0]    load;
  logic              accept;
  logic              drop;
  logic [CW-1:0]     drop_q;

  assign chan_ready = {bus.f_ready, bus.k_ready, bus.c_ready};

  // A channel can take a word when it is empty or is being emptied on this same edge.
  always_comb begin
    space = '0;
    for (int i = 0; i < NCH; i++) begin
      space[i] = (state[i] == EMPTY) || chan_ready[i];
    end
  end

  always_comb begin
    bus.in_ready = 1'b1;
    case (bus.in_sel)
      2'd0:    bus.in_ready = space[0];
      2'd1:    bus.in_ready = space[1];
      2'd2:    bus.in_ready = space[2];
      default: bus.in_ready = 1'b1;
    endcase
  end

  assign accept = bus.in_valid && bus.in_ready;
  assign drop   = accept && (bus.in_sel == 2'd3);

  always_comb begin
    load = '0;
    for (int i = 0; i < NCH; i++) begin
      load[i] = accept && (bus.in_sel == 2'(i));
    end
  end

  // Load wins over drain, which gives back-to-back transfers with no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        state[i]  <= EMPTY;
        data_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (load[i]) begin
          state[i]  <= FULL;
          data_q[i] <= bus.in_data;
        end else if ((state[i] == FULL) && chan_ready[i]) begin
          state[i]  <= EMPTY;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q <= '0;
    end else if (drop && (drop_q != {CW{1'b1}})) begin
      drop_q <= drop_q + 1'b1;
    end
  end

  assign bus.c_data     = data_q[0];
  assign bus.k_data     = data_q[1];
  assign bus.f_data     = data_q[2];
  assign bus.c_valid    = (state[0] == FULL);
  assign bus.k_valid    = (state[1] == FULL);
  assign bus.f_valid    = (state[2] == FULL);
  assign bus.drop_count = drop_q;

endmodule

// File: tb/tb_midterm_demux.sv
// Directed bench for midterm_demux: an occupancy model of the three channels and the drop
// counter is compared against the DUT on every falling edge, plus literal spot checks.
module tb_midterm_demux;

  localparam int W  = 4;
  localparam int CW = 2;
  localparam int MAX_DROPS = (1 << CW) - 1;

  logic clk;
  logic rst_n;

  midterm_demux_if #(.W(W), .CW(CW)) bus ();

  midterm_demux #(.W(W), .CW(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  // Model: each channel either holds one word or holds nothing; drops are a plain count.
  bit         m_full [3];
  int         m_word [3];
  int         m_drops;

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic bit ready_of(input int ch);
    case (ch)
      0:       return bus.c_ready;
      1:       return bus.k_ready;
      default: return bus.f_ready;
    endcase
  endfunction

  function automatic bit model_in_ready();
    int ch;
    ch = int'(bus.in_sel);
    if (ch == 3) return 1'b1;
    return !m_full[ch] || ready_of(ch);
  endfunction

  always @(negedge rst_n) begin
    for (int i = 0; i < 3; i++) begin
      m_full[i] = 1'b0;
      m_word[i] = 0;
    end
    m_drops = 0;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      bit took;
      int dest;
      took = bus.in_valid && model_in_ready();
      dest = int'(bus.in_sel);
      for (int i = 0; i < 3; i++) begin
        if (took && dest == i) begin
          m_full[i] = 1'b1;
          m_word[i] = int'(bus.in_data);
        end else if (m_full[i] && ready_of(i)) begin
          m_full[i] = 1'b0;
        end
      end
      if (took && dest == 3) m_drops = (m_drops + 1 > MAX_DROPS) ? MAX_DROPS : m_drops + 1;
    end
  end

  always @(negedge clk) begin
    check_output("in_ready",   int'(bus.in_ready),   int'(model_in_ready()));
    check_output("c_valid",    int'(bus.c_valid),    int'(m_full[0]));
    check_output("k_valid",    int'(bus.k_valid),    int'(m_full[1]));
    check_output("f_valid",    int'(bus.f_valid),    int'(m_full[2]));
    check_output("c_data",     int'(bus.c_data),     m_word[0]);
    check_output("k_data",     int'(bus.k_data),     m_word[1]);
    check_output("f_data",     int'(bus.f_data),     m_word[2]);
    check_output("drop_count", int'(bus.drop_count), m_drops);
  end

  task automatic apply_stimulus(input bit v, input int sel, input int d,
                                input bit cr, input bit kr, input bit fr);
    bus.in_valid = v;
    bus.in_sel   = 2'(sel);
    bus.in_data  = W'(d);
    bus.c_ready  = cr;
    bus.k_ready  = kr;
    bus.f_ready  = fr;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    apply_stimulus(0, 0, 0, 0, 0, 0);
    repeat (3) step();
    rst_n = 1'b1;
    check_output("reset_drop_count", int'(bus.drop_count), 0);
    check_output("reset_c_valid", int'(bus.c_valid), 0);

    // Single route to K
    apply_stimulus(1, 1, 'hA, 0, 0, 0);
    check_output("route_in_ready", int'(bus.in_ready), 1);
    step();
    check_output("route_k_valid", int'(bus.k_valid), 1);
    check_output("route_k_data",  int'(bus.k_data), 'hA);
    check_output("route_c_valid", int'(bus.c_valid), 0);
    check_output("route_f_valid", int'(bus.f_valid), 0);

    // Backpressure on K, then drain and load on one edge
    apply_stimulus(1, 1, 'h5, 0, 0, 0);
    check_output("bp_in_ready", int'(bus.in_ready), 0);
    step();
    check_output("bp_k_hold", int'(bus.k_data), 'hA);
    apply_stimulus(1, 1, 'h5, 0, 1, 0);
    check_output("bp_in_ready_release", int'(bus.in_ready), 1);
    step();
    check_output("bp_k_valid", int'(bus.k_valid), 1);
    check_output("bp_k_data",  int'(bus.k_data), 'h5);
    apply_stimulus(0, 1, 0, 0, 1, 0);
    step();
    check_output("bp_k_drained", int'(bus.k_valid), 0);

    // Streaming through F with no gaps
    for (int d = 0; d < 16; d++) begin
      apply_stimulus(1, 2, d, 0, 0, 1);
      step();
      check_output("stream_f_valid", int'(bus.f_valid), 1);
      check_output("stream_f_data",  int'(bus.f_data), d);
    end
    apply_stimulus(0, 2, 0, 0, 0, 1);
    step();
    check_output("stream_f_empty", int'(bus.f_valid), 0);

    // Independence: C held full, F still loads
    apply_stimulus(1, 0, 'h3, 0, 0, 0);
    step();
    apply_stimulus(1, 0, 'h7, 0, 0, 0);
    check_output("indep_in_ready_c", int'(bus.in_ready), 0);
    step();
    apply_stimulus(1, 2, 'h9, 0, 0, 0);
    check_output("indep_in_ready_f", int'(bus.in_ready), 1);
    step();
    check_output("indep_f_data", int'(bus.f_data), 'h9);
    check_output("indep_c_data", int'(bus.c_data), 'h3);

    // Fill K too, then drop saturation with all channels full
    apply_stimulus(1, 1, 'h6, 0, 0, 0);
    step();
    for (int n = 1; n <= 5; n++) begin
      apply_stimulus(1, 3, n, 0, 0, 0);
      step();
      check_output("drop_count_sat", int'(bus.drop_count), (n > 3) ? 3 : n);
      check_output("drop_valids", int'({bus.c_valid, bus.k_valid, bus.f_valid}), 7);
    end

    // Asynchronous reset mid-cycle with all three channels full
    apply_stimulus(0, 0, 0, 0, 0, 0);
    #1;
    rst_n = 1'b0;
    #1;
    check_output("async_valids", int'({bus.c_valid, bus.k_valid, bus.f_valid}), 0);
    check_output("async_data", int'({bus.c_data, bus.k_data, bus.f_data}), 0);
    check_output("async_drops", int'(bus.drop_count), 0);
    step();
    rst_n = 1'b1;

    // Load all three, then drain them on the same edge while a new word lands in C
    for (int ch = 0; ch < 3; ch++) begin
      apply_stimulus(1, ch, ch + 'hB, 0, 0, 0);
      step();
    end
    apply_stimulus(1, 0, 'h1, 1, 1, 1);
    step();
    check_output("multi_drain_c", int'(bus.c_data), 'h1);
    check_output("multi_drain_kf", int'({bus.k_valid, bus.f_valid}), 0);
    apply_stimulus(0, 0, 0, 1, 1, 1);
    repeat (2) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
